// File: rtl/conv_mem_host.sv
// Memory-side responder for the convolution engine: image store, L0/L1 result
// stores, start handshake, run supervision and host dump port.
module conv_mem_host #(
  parameter int DW          = 20,
  parameter int AW          = 12,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          img_we,
  input  logic [AW-1:0] img_waddr,
  input  logic [DW-1:0] img_wdata,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic [2:0]    csel,
  input  logic [1:0]    dump_sel,
  input  logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          done,
  output logic          timeout,
  output logic          err,
  output logic [12:0]   l0_wr_cnt,
  output logic [10:0]   l1_wr_cnt
);

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;
  localparam int         CW      = $clog2(TIMEOUT_CYC + 1);
  localparam int         IMG_N   = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RUN, S_DONE} state_e;

  logic [DW-1:0] img_mem [0:IMG_N-1];
  logic [DW-1:0] l0_mem  [0:4095];
  logic [DW-1:0] l1_mem  [0:1023];

  state_e        state_q, state_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          err_q, err_d;
  logic [12:0]   l0_cnt_q, l0_cnt_d;
  logic [10:0]   l1_cnt_q, l1_cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [DW-1:0] dump_q, dump_d;

  logic in_idle, in_run, sel_l0, sel_l1, l1_addr_ok;
  logic img_wr_en, l0_wr_en, l1_wr_en, illegal;

  assign in_idle    = (state_q == S_IDLE);
  assign in_run     = (state_q == S_RUN);
  assign sel_l0     = (csel == CSEL_L0);
  assign sel_l1     = (csel == CSEL_L1);
  assign l1_addr_ok = (caddr_wr < AW'(1024));

  // Reset gates the write enables so a reset edge never commits a write.
  assign img_wr_en = img_we & in_idle & ~reset;
  assign l0_wr_en  = cwr & in_run & sel_l0 & ~reset;
  assign l1_wr_en  = cwr & in_run & sel_l1 & l1_addr_ok & ~reset;

  assign illegal = (img_we & ~in_idle)
                 | (cwr & ~in_run)
                 | (cwr & in_run & ~(sel_l0 | (sel_l1 & l1_addr_ok)))
                 | (crd & ~sel_l0 & ~sel_l1);

  assign idata = img_mem[iaddr];

  always_comb begin
    cdata_rd = '0;
    if (crd) begin
      if (sel_l0)      cdata_rd = l0_mem[caddr_rd];
      else if (sel_l1) cdata_rd = l1_mem[caddr_rd[9:0]];
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    err_d     = err_q | illegal;
    cyc_d     = cyc_q;
    l0_cnt_d  = l0_cnt_q;
    l1_cnt_d  = l1_cnt_q;
    dump_d    = '0;

    if (l0_wr_en && l0_cnt_q != '1) l0_cnt_d = l0_cnt_q + 13'd1;
    if (l1_wr_en && l1_cnt_q != '1) l1_cnt_d = l1_cnt_q + 11'd1;

    unique case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_REQ;
        timeout_d = 1'b0;
        err_d     = 1'b0;
        l0_cnt_d  = '0;
        l1_cnt_d  = '0;
      end
      S_REQ: if (busy) begin
        state_d = S_RUN;
        cyc_d   = '0;
      end
      S_RUN: begin
        cyc_d = cyc_q + 1'b1;
        // Engine completion wins over a timeout landing on the same cycle.
        if (!busy) begin
          state_d = S_DONE;
        end else if (cyc_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_REQ);
    done_d  = (state_d == S_DONE);

    unique case (dump_sel)
      2'd0:    dump_d = img_mem[dump_addr];
      2'd1:    dump_d = l0_mem[dump_addr];
      2'd2:    dump_d = l1_mem[dump_addr[9:0]];
      default: dump_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      l0_cnt_q  <= '0;
      l1_cnt_q  <= '0;
      cyc_q     <= '0;
      dump_q    <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      l0_cnt_q  <= l0_cnt_d;
      l1_cnt_q  <= l1_cnt_d;
      cyc_q     <= cyc_d;
      dump_q    <= dump_d;
    end
  end

  // Storage arrays are never cleared; reads before a write see old contents.
  always_ff @(posedge clk) begin
    if (img_wr_en) img_mem[img_waddr]     <= img_wdata;
    if (l0_wr_en)  l0_mem[caddr_wr]       <= cdata_wr;
    if (l1_wr_en)  l1_mem[caddr_wr[9:0]]  <= cdata_wr;
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign err       = err_q;
  assign l0_wr_cnt = l0_cnt_q;
  assign l1_wr_cnt = l1_cnt_q;
  assign dump_data = dump_q;

endmodule

// File: tb/tb_conv_mem_host.sv
// Directed bench for conv_mem_host: handshake, memory paths, counters,
// error/timeout flags and reset behaviour, with hand-computed expectations.
module tb_conv_mem_host;
  localparam int DW = 20;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          img_we;
  logic [AW-1:0] img_waddr;
  logic [DW-1:0] img_wdata;
  logic          start, busy, crd, cwr;
  logic [AW-1:0] iaddr, caddr_rd, caddr_wr, dump_addr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;
  logic [1:0]    dump_sel;

  logic          ready, done, timeout, err;
  logic [DW-1:0] idata, cdata_rd, dump_data;
  logic [12:0]   l0_wr_cnt;
  logic [10:0]   l1_wr_cnt;

  logic          t_ready, t_done, t_timeout, t_err;
  logic [DW-1:0] t_idata, t_cdata_rd, t_dump_data;
  logic [12:0]   t_l0_wr_cnt;
  logic [10:0]   t_l1_wr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_mem_host #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .img_we(img_we), .img_waddr(img_waddr),
    .img_wdata(img_wdata), .start(start), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .csel(csel), .dump_sel(dump_sel), .dump_addr(dump_addr),
    .dump_data(dump_data), .done(done), .timeout(timeout), .err(err),
    .l0_wr_cnt(l0_wr_cnt), .l1_wr_cnt(l1_wr_cnt)
  );

  // Short-timeout copy sharing the same stimulus.
  conv_mem_host #(.DW(DW), .AW(AW), .TIMEOUT_CYC(100)) dut_to (
    .clk(clk), .reset(reset), .img_we(img_we), .img_waddr(img_waddr),
    .img_wdata(img_wdata), .start(start), .ready(t_ready), .busy(busy),
    .iaddr(iaddr), .idata(t_idata), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(t_cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .csel(csel), .dump_sel(dump_sel), .dump_addr(dump_addr),
    .dump_data(t_dump_data), .done(t_done), .timeout(t_timeout), .err(t_err),
    .l0_wr_cnt(t_l0_wr_cnt), .l1_wr_cnt(t_l1_wr_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cyc_seen;
    reset = 1'b1; img_we = 0; img_waddr = '0; img_wdata = '0; start = 0;
    busy = 0; iaddr = '0; crd = 0; caddr_rd = '0; cwr = 0; caddr_wr = '0;
    cdata_wr = '0; csel = 3'b000; dump_sel = 2'd3; dump_addr = '0;
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err, 0);
    chk("rst_l0cnt", l0_wr_cnt, 0);
    chk("rst_l1cnt", l1_wr_cnt, 0);
    chk("rst_dump", dump_data, 0);

    // Image preload: img[a] = a
    for (int a = 0; a < 4096; a++) begin
      img_we = 1; img_waddr = AW'(a); img_wdata = DW'(a);
      tick();
    end
    img_we = 0;
    dump_sel = 2'd0; dump_addr = 12'h7FF;
    tick();
    chk("dump_img_7ff", dump_data, 20'h007FF);
    chk("preload_err", err, 0);

    // Handshake
    start = 1; tick(); start = 0;
    chk("req_ready", ready, 1);
    busy = 1; tick();
    chk("run_ready_low", ready, 0);
    iaddr = 12'h123; #1;
    chk("idata_123", idata, 20'h00123);

    // L0 write / read back
    cwr = 1; csel = 3'b001; caddr_wr = 12'hFFF; cdata_wr = 20'h0ABCD;
    tick(); cwr = 0;
    crd = 1; caddr_rd = 12'hFFF; #1;
    chk("l0_rd_fff", cdata_rd, 20'h0ABCD);
    chk("l0_cnt_1", l0_wr_cnt, 1);
    // Same-word read during write returns old data
    cwr = 1; cdata_wr = 20'h12345; #1;
    chk("rd_before_wr", cdata_rd, 20'h0ABCD);
    tick(); cwr = 0; #1;
    chk("rd_after_wr", cdata_rd, 20'h12345);
    chk("l0_cnt_2", l0_wr_cnt, 2);
    crd = 0; #1;
    chk("crd0_zero", cdata_rd, 0);

    // L1 write and dump
    cwr = 1; csel = 3'b011; caddr_wr = 12'h3FF; cdata_wr = 20'hF0001;
    tick(); cwr = 0;
    dump_sel = 2'd2; dump_addr = 12'h3FF;
    tick();
    chk("dump_l1_3ff", dump_data, 20'hF0001);
    chk("l1_cnt_1", l1_wr_cnt, 1);
    chk("err_before_oob", err, 0);
    cwr = 1; caddr_wr = 12'h400; cdata_wr = 20'h11111;
    tick(); cwr = 0;
    chk("err_l1_oob", err, 1);
    chk("l1_cnt_oob", l1_wr_cnt, 1);
    dump_sel = 2'd1; dump_addr = 12'hFFF; tick();
    chk("dump_l0_fff", dump_data, 20'h12345);
    dump_sel = 2'd3; tick();
    chk("dump_reserved", dump_data, 0);
    // Image write outside IDLE is dropped
    img_we = 1; img_waddr = 12'h123; img_wdata = 20'hFFFFF;
    tick(); img_we = 0; iaddr = 12'h123; #1;
    chk("img_we_run_drop", idata, 20'h00123);

    busy = 0; tick();
    chk("done_pulse", done, 1);
    chk("done_timeout", timeout, 0);
    tick();
    chk("done_low", done, 0);

    // Full run: 4096 L0 + 1024 L1 writes
    start = 1; tick(); start = 0;
    chk("run2_err_clr", err, 0);
    chk("run2_l0_clr", l0_wr_cnt, 0);
    chk("run2_l1_clr", l1_wr_cnt, 0);
    busy = 1; tick();
    csel = 3'b001;
    for (int i = 0; i < 4096; i++) begin
      cwr = 1; caddr_wr = AW'(i); cdata_wr = 20'h10000 | DW'(i);
      tick();
    end
    csel = 3'b011;
    for (int i = 0; i < 1024; i++) begin
      cwr = 1; caddr_wr = AW'(i); cdata_wr = 20'h80000 | DW'(i);
      tick();
    end
    cwr = 0; busy = 0; tick();
    chk("full_done", done, 1);
    chk("full_l0cnt", l0_wr_cnt, 4096);
    chk("full_l1cnt", l1_wr_cnt, 1024);
    chk("full_err", err, 0);
    chk("full_timeout", timeout, 0);
    tick();
    chk("full_done_low", done, 0);
    dump_sel = 2'd1; dump_addr = 12'h800; tick();
    chk("dump_l0_800", dump_data, 20'h10800);
    dump_sel = 2'd2; dump_addr = 12'h155; tick();
    chk("dump_l1_155", dump_data, 20'h80155);
    dump_addr = 12'hC05; tick();
    chk("dump_l1_wrap", dump_data, 20'h80005);
    dump_sel = 2'd0; dump_addr = 12'hABC; tick();
    chk("dump_img_abc", dump_data, 20'h00ABC);

    // Timeout on the short-timeout instance
    start = 1; tick(); start = 0;
    busy = 1; tick();
    cyc_seen = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (t_done) begin
        cyc_seen = k;
        break;
      end
    end
    chk("to_cycles", cyc_seen, 100);
    chk("to_flag", t_timeout, 1);
    chk("main_no_to", done, 0);
    busy = 0; tick(); tick(); tick();
    start = 1; tick(); start = 0;
    chk("to_clr_req", t_timeout, 0);
    chk("to_req_ready", t_ready, 1);
    busy = 1; tick(); busy = 0; tick(); tick(); tick();

    // Reset in the middle of a run with a pending write
    start = 1; tick(); start = 0;
    busy = 1; tick();
    cwr = 1; csel = 3'b001; caddr_wr = 12'h800; cdata_wr = 20'h77777;
    reset = 1; tick();
    reset = 0; cwr = 0; busy = 0;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_l0cnt", l0_wr_cnt, 0);
    chk("mid_rst_err", err, 0);
    dump_sel = 2'd1; dump_addr = 12'h800; tick();
    chk("mid_rst_l0_kept", dump_data, 20'h10800);
    img_we = 1; img_waddr = 12'h005; img_wdata = 20'h55555; tick(); img_we = 0;
    dump_sel = 2'd0; dump_addr = 12'h005; tick();
    chk("mid_rst_idle_img", dump_data, 20'h55555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
